// File: rtl/weight_update_writer.sv
// Consumer of backprop_stack weight-update records: read-modify-write of one weight row per record,
// w_new = w - ((lr * grad) >>> 8) in Q8.8. Define WEIGHT_UPDATE_SAT_EN to saturate lanes instead of wrapping.
module weight_update_writer #(
    parameter int unsigned max_layer_size = 4,
    parameter int unsigned data_size      = 16,
    parameter int unsigned size           = 3,
    parameter int unsigned addr_width     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          active_train,
    input  logic [data_size-1:0]          learning_rate,
    output logic                          read_update_data,
    input  logic                          is_update_weight,
    input  logic [size*data_size-1:0]     update_weight_value,
    input  logic [31:0]                   update_weight_row,
    input  logic [31:0]                   update_weight_layer,
    output logic [addr_width-1:0]         mem_addr,
    output logic                          mem_rd_en,
    input  logic [size*data_size-1:0]     mem_rd_data,
    output logic                          mem_wr_en,
    output logic [size*data_size-1:0]     mem_wr_data,
    output logic                          update_done,
    output logic                          drop_error,
    output logic [15:0]                   update_count
);

    localparam int unsigned DW   = data_size;
    localparam int unsigned RowW = size * data_size;
    localparam int unsigned PW   = 2 * data_size;
    localparam int unsigned RW   = 2 * data_size + 1;
    localparam int unsigned FRAC = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } state_e;

    state_e                state_q;
    logic [RowW-1:0]       grad_q;
    logic [DW-1:0]         lr_q;
    logic [addr_width-1:0] addr_q;
    logic                  rd_en_q;
    logic                  wr_en_q;
    logic [RowW-1:0]       wr_data_q;
    logic [RowW-1:0]       wr_data_d;
    logic                  done_q;
    logic                  drop_q;
    logic [15:0]           count_q;
    logic                  capture;
    logic [31:0]           addr_full;

    // One lane: product at 2*DW bits, floor shift, subtract at 2*DW+1 bits, then narrow.
    function automatic logic [DW-1:0] lane_update(input logic signed [DW-1:0] w,
                                                  input logic signed [DW-1:0] g,
                                                  input logic signed [DW-1:0] lr);
        logic signed [PW-1:0] p;
        logic signed [PW-1:0] delta;
        logic signed [RW-1:0] r;
        p     = g * lr;
        delta = p >>> FRAC;
        r     = RW'(w) - RW'(delta);
`ifdef WEIGHT_UPDATE_SAT_EN
        if (r[RW-1:DW-1] != {(RW-DW+1){r[RW-1]}}) begin
            return r[RW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
        return r[DW-1:0];
`else
        return r[DW-1:0];
`endif
    endfunction

    // Lane 0 sits in the MSBs of every row bus.
    always_comb begin
        wr_data_d = '0;
        for (int i = 0; i < int'(size); i++) begin
            wr_data_d[(size-1-i)*DW +: DW] = lane_update(mem_rd_data[(size-1-i)*DW +: DW],
                                                         grad_q[(size-1-i)*DW +: DW],
                                                         lr_q);
        end
    end

    assign read_update_data = rst_n && (state_q == S_IDLE) && active_train;
    assign capture          = read_update_data && is_update_weight;
    assign addr_full        = update_weight_layer * 32'(max_layer_size) + update_weight_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            grad_q    <= '0;
            lr_q      <= '0;
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            drop_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (capture) begin
                        grad_q <= update_weight_value;
                        lr_q   <= learning_rate;
                        if (update_weight_row >= 32'(max_layer_size)) begin
                            drop_q <= 1'b1;
                        end else begin
                            addr_q  <= addr_width'(addr_full);
                            rd_en_q <= 1'b1;
                            state_q <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    wr_data_q <= wr_data_d;
                    wr_en_q   <= 1'b1;
                    done_q    <= 1'b1;
                    count_q   <= count_q + 16'd1;
                    state_q   <= S_WRITE;
                end
                S_WRITE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr     = addr_q;
    assign mem_rd_en    = rd_en_q;
    assign mem_wr_en    = wr_en_q;
    assign mem_wr_data  = wr_data_q;
    assign update_done  = done_q;
    assign drop_error   = drop_q;
    assign update_count = count_q;

endmodule

// File: tb/tb_weight_update_writer.sv
// Scoreboard bench for weight_update_writer: expected writes are queued at drive time, popped on mem_wr_en.
module tb_weight_update_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        active_train;
    logic [15:0] learning_rate;
    logic        read_update_data;
    logic        is_update_weight;
    logic [47:0] update_weight_value;
    logic [31:0] update_weight_row;
    logic [31:0] update_weight_layer;
    logic [7:0]  mem_addr;
    logic        mem_rd_en;
    logic [47:0] mem_rd_data;
    logic        mem_wr_en;
    logic [47:0] mem_wr_data;
    logic        update_done;
    logic        drop_error;
    logic [15:0] update_count;

    weight_update_writer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .active_train        (active_train),
        .learning_rate       (learning_rate),
        .read_update_data    (read_update_data),
        .is_update_weight    (is_update_weight),
        .update_weight_value (update_weight_value),
        .update_weight_row   (update_weight_row),
        .update_weight_layer (update_weight_layer),
        .mem_addr            (mem_addr),
        .mem_rd_en           (mem_rd_en),
        .mem_rd_data         (mem_rd_data),
        .mem_wr_en           (mem_wr_en),
        .mem_wr_data         (mem_wr_data),
        .update_done         (update_done),
        .drop_error          (drop_error),
        .update_count        (update_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [47:0] data;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [47:0] mem [256];
    int          n_vec = 0;
    int          n_err = 0;
    int          cnt   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference lane math on plain ints: floor shift, then wrap or clamp.
    function automatic logic [47:0] model(input logic [47:0] w, input logic [47:0] g, input logic [15:0] lr);
        logic [47:0] res;
        int wi, gi, li, r;
        res = '0;
        li  = int'($signed(lr));
        for (int i = 0; i < 3; i++) begin
            wi = int'($signed(w[47-16*i -: 16]));
            gi = int'($signed(g[47-16*i -: 16]));
            r  = wi - ((gi * li) >>> 8);
`ifdef WEIGHT_UPDATE_SAT_EN
            if (r > 32767)  r = 32767;
            if (r < -32768) r = -32768;
`endif
            res[47-16*i -: 16] = 16'(r);
        end
        return res;
    endfunction

    // Weight RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (rst_n && mem_wr_en) begin
            if (sb.size() == 0) begin
                check("spurious_wr", 1, 0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.addr));
                check("wr_data", 64'(mem_wr_data), 64'(e.data));
                check("wr_count", 64'(update_count), 64'(e.cnt));
                check("wr_done", 64'(update_done), 1);
            end
        end
    end

    task automatic send(input logic [31:0] layer, input logic [31:0] row, input logic [47:0] g,
                        input logic [15:0] lr, input bit keep_train);
        logic [7:0] a;
        bit         drop;
        a    = 8'(layer * 4 + row);
        drop = (row >= 4);
        @(negedge clk);
        active_train        = 1'b1;
        learning_rate       = lr;
        update_weight_value = g;
        update_weight_row   = row;
        update_weight_layer = layer;
        is_update_weight    = 1'b1;
        #1 check("rd_req", 64'(read_update_data), 1);
        if (!drop) begin
            cnt++;
            sb.push_back('{addr: a, data: model(mem[a], g, lr), cnt: 16'(cnt)});
        end
        @(posedge clk);
        #1;
        is_update_weight = 1'b0;
        if (!keep_train) active_train = 1'b0;
        @(negedge clk);
        if (drop) begin
            check("drop_pulse", 64'(drop_error), 1);
            check("drop_no_rd", 64'(mem_rd_en), 0);
            check("drop_req", 64'(read_update_data), 64'(keep_train));
            @(negedge clk);
            check("drop_once", 64'(drop_error), 0);
            check("drop_no_mem", 64'({mem_rd_en, mem_wr_en}), 0);
            check("drop_count", 64'(update_count), 64'(cnt));
        end else begin
            check("rd_en_t1", 64'(mem_rd_en), 1);
            check("rd_addr", 64'(mem_addr), 64'(a));
            check("req_busy", 64'(read_update_data), 0);
            @(negedge clk);
            check("wait_quiet", 64'({mem_rd_en, mem_wr_en}), 0);
            @(negedge clk);
            check("wr_en_t3", 64'(mem_wr_en), 1);
            @(negedge clk);
            check("wr_once", 64'({mem_wr_en, update_done}), 0);
            check("req_t4", 64'(read_update_data), 64'(keep_train));
        end
        active_train = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 48'(i * 32'h0001_0203);
        rst_n               = 1'b0;
        active_train        = 1'b1;
        learning_rate       = '0;
        is_update_weight    = 1'b0;
        update_weight_value = '0;
        update_weight_row   = '0;
        update_weight_layer = '0;
        #12;
        check("rst_req", 64'(read_update_data), 0);
        check("rst_outs", 64'({mem_rd_en, mem_wr_en, update_done, drop_error}), 0);
        check("rst_addr", 64'(mem_addr), 0);
        check("rst_wdata", 64'(mem_wr_data), 0);
        check("rst_count", 64'(update_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("post_rst_req", 64'(read_update_data), 1);

        // Basic RMW
        mem[1] = {16'h0100, 16'h0100, 16'h0100};
        send(0, 1, {16'h0200, 16'h0100, 16'hFE00}, 16'h0080, 1'b1);
        check("basic_data", 64'(mem_wr_data), 64'({16'h0000, 16'h0080, 16'h0200}));

        // Addressing
        send(2, 3, {16'h0040, 16'hFFC0, 16'h1000}, 16'h0100, 1'b1);

        // Overflow
        mem[5] = {16'h7F00, 16'h0000, 16'h0000};
        send(1, 1, {16'h8000, 16'h0000, 16'h0000}, 16'h0100, 1'b1);
`ifdef WEIGHT_UPDATE_SAT_EN
        check("ovf_lane0", 64'(mem_wr_data[47:32]), 64'(16'h7FFF));
`else
        check("ovf_lane0", 64'(mem_wr_data[47:32]), 64'(16'hFF00));
`endif

        // Random records, including train dropped mid-RMW
        for (int k = 0; k < 6; k++) begin
            send(32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)), {$urandom, 16'($urandom)},
                 16'($urandom), bit'(k % 2));
        end

        // Drop on out-of-range row
        send(0, 4, {16'h0100, 16'h0100, 16'h0100}, 16'h0100, 1'b1);

        // Gating: valid held while training is off
        @(negedge clk);
        active_train        = 1'b0;
        update_weight_row   = 2;
        update_weight_layer = 1;
        is_update_weight    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("gate_req", 64'(read_update_data), 0);
            check("gate_mem", 64'({mem_rd_en, mem_wr_en, drop_error}), 0);
        end
        send(1, 2, {16'h0300, 16'h0010, 16'hF000}, 16'h0020, 1'b1);

        // Reset during WAIT
        @(negedge clk);
        update_weight_row   = 0;
        update_weight_layer = 1;
        update_weight_value = 48'h1111_2222_3333;
        learning_rate       = 16'h0100;
        is_update_weight    = 1'b1;
        @(posedge clk);
        #1 is_update_weight = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_outs", 64'({read_update_data, mem_rd_en, mem_wr_en, update_done, drop_error}), 0);
        check("mid_rst_addr", 64'(mem_addr), 0);
        check("mid_rst_wdata", 64'(mem_wr_data), 0);
        check("mid_rst_count", 64'(update_count), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_rst_no_wr", 64'(mem_wr_en), 0);
        end
        active_train = 1'b0;
        rst_n        = 1'b1;
        #1 check("rel_req_off", 64'(read_update_data), 0);
        active_train = 1'b1;
        #1 check("rel_req_on", 64'(read_update_data), 1);
        cnt = 0;
        send(3, 0, {16'h0080, 16'h0080, 16'h0080}, 16'h0200, 1'b1);

        repeat (4) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/weight_update_writer.md
Name: weight_update_writer

Overview:
- Consumer end of the backprop_stack weight-update interface.
- Requests update records with read_update_data and captures each record when is_update_weight is high.
- For each record it performs a read-modify-write of one weight row in the weight memory: w_new = w - ((lr * grad) >>> 8), in Q8.8 fixed point.
- Sits between backprop_stack and the dense-layer weight RAM.

Parameters:
- max_layer_size, 4, neurons per layer; rows per layer in weight memory.
- data_size, 16, bits per fixed-point lane (Q8.8).
- size, 3, lanes per weight row.
- addr_width, 8, weight-memory address width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- active_train  input  1  training enable; gates new requests.
- learning_rate  input  data_size  signed Q8.8 step size; sampled at capture.
- read_update_data  output  1  request to backprop_stack for the next update record.
- is_update_weight  input  1  update record valid.
- update_weight_value  input  size*data_size  signed gradient lanes; lane 0 in the MSBs.
- update_weight_row  input  32  target row.
- update_weight_layer  input  32  target layer.
- mem_addr  output  addr_width  weight-memory address.
- mem_rd_en  output  1  read strobe; data returns 1 cycle later.
- mem_rd_data  input  size*data_size  weight row read data.
- mem_wr_en  output  1  write strobe.
- mem_wr_data  output  size*data_size  updated weight row.
- update_done  output  1  1-cycle pulse when a write completes.
- drop_error  output  1  1-cycle pulse when a record is discarded.
- update_count  output  16  number of completed writes; wraps.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; every output 0, including mem_addr, mem_wr_data and update_count.
- States: IDLE, READ, WAIT, WRITE.
- IDLE:
  - read_update_data = active_train; combinational from state and active_train.
  - Capture happens on an edge where read_update_data && is_update_weight.
  - At capture, latch grad, row, layer and learning_rate.
  - If row >= max_layer_size: pulse drop_error next cycle and stay in IDLE.
  - Otherwise go to READ.
  - is_update_weight while read_update_data=0 is ignored; no capture.
- READ (1 cycle):
  - read_update_data=0, mem_rd_en=1.
  - mem_addr = (layer*max_layer_size + row), truncated to addr_width.
  - Next state WAIT.
- WAIT (1 cycle):
  - mem_rd_data is valid this cycle.
  - Register per-lane results; next state WRITE.
- WRITE (1 cycle):
  - mem_wr_en=1; mem_addr unchanged from READ; mem_wr_data = registered results.
  - update_done=1; update_count increments.
  - Next state IDLE.
- Latency and throughput:
  - Capture at edge T, mem_rd_en high in cycle T+1, mem_wr_en high in cycle T+3.
  - read_update_data reasserts in cycle T+4.
  - Maximum throughput is 1 record per 4 cycles.
- Lane arithmetic (signed):
  - p = grad_i * lr, 2*data_size bits.
  - delta = p >>> 8, arithmetic shift (floor).
  - r = w_i - delta, computed at 2*data_size+1 bits.
  - Result is r clamped or wrapped to data_size bits; see Optional Feature.
- Other rules:
  - mem_addr holds its last value in IDLE.
  - mem_rd_en, mem_wr_en, update_done and drop_error are 0 outside the states listed above.
  - active_train dropping mid-RMW does not abort the transaction; it only blocks the next request.
  - Reset mid-RMW aborts immediately and no write is issued. A write in progress at the reset edge is cut off combinationally.

Optional Feature:
- Macro: WEIGHT_UPDATE_SAT_EN.
- Defined: r is saturated to [-2^(data_size-1), 2^(data_size-1)-1], i.e. 0x8000..0x7FFF for the default width.
- Undefined: result = low data_size bits of r (two's-complement wrap).

Test Plan:
- Basic RMW:
  - Stimulus: lr=0x0080 (0.5); grad lanes 0x0200, 0x0100, 0xFE00; layer=0, row=1; mem_rd_data lanes 0x0100, 0x0100, 0x0100.
  - Response: mem_addr=1; mem_wr_data lanes 0x0000, 0x0080, 0x0200; mem_wr_en exactly 3 cycles after capture; update_done pulse; update_count=1.
- Addressing:
  - Stimulus: layer=2, row=3, max_layer_size=4.
  - Response: mem_addr=11 on both the mem_rd_en and mem_wr_en cycles.
- Overflow:
  - Stimulus: w=0x7F00, grad=0x8000, lr=0x0100.
  - Response: mem_wr_data lane=0x7FFF with WEIGHT_UPDATE_SAT_EN defined; 0xFF00 without it.
- Drop:
  - Stimulus: row=4.
  - Response: drop_error pulses once; no mem_rd_en or mem_wr_en; read_update_data stays high; update_count unchanged.
- Gating:
  - Stimulus: active_train=0 with is_update_weight=1 held.
  - Response: read_update_data=0; no memory activity.
  - Then raise active_train: capture on the next edge.
- Reset mid-operation:
  - Stimulus: drive rst_n=0 during WAIT.
  - Response: all outputs 0 immediately; no mem_wr_en.
  - After release: state IDLE, read_update_data follows active_train.
